f8_uart_tx: RTL and testbench

Memory-mapped UART transmitter peripheral for the f8 system, sitting on the f8 I/O bus beside the GPIO ports. Software writes bytes into a 4-entry FIFO. The block serialises them as 8N1 frames on a single output pin. A system-level bench watching that pin can decode program output without relying on trap or GPIO side channels.

---
 rtl/f8_uart_pkg.sv | 22 ++
 rtl/f8_uart_tx_if.sv | 18 +
 rtl/f8_sync_fifo.sv | 51 +++++
 rtl/f8_uart_tx.sv | 152 +++++++++++++++
 tb/tb_f8_uart_tx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/f8_uart_pkg.sv
// f8_uart_pkg: shared definitions for the f8 UART transmitter.
//   uart_state_t   - transmitter FSM state encoding
//   DATA_ADDR      - register offset of the DATA (write FIFO) register
//   STATUS_ADDR    - register offset of the STATUS register
//   *_BIT          - STATUS bit positions
package f8_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam logic DATA_ADDR   = 1'b0;
   localparam logic STATUS_ADDR = 1'b1;

   localparam int FULL_BIT = 0;
   localparam int BUSY_BIT = 1;
   localparam int OVF_BIT  = 2;

endpackage

// File: rtl/f8_uart_tx_if.sv
// f8_uart_tx_if: f8 I/O bus slice seen by the UART transmitter.
//   sel   - peripheral selected by the I/O decoder
//   addr  - register offset (0 = DATA, 1 = STATUS)
//   wr    - write strobe, qualified by sel
//   rd    - read strobe, qualified by sel
//   wdata - write data
//   rdata - read data, combinational from addr
interface f8_uart_tx_if;
   logic       sel;
   logic       addr;
   logic       wr;
   logic       rd;
   logic [7:0] wdata;
   logic [7:0] rdata;

   modport master (output sel, addr, wr, rd, wdata, input rdata);
   modport slave  (input sel, addr, wr, rd, wdata, output rdata);
endinterface

// File: rtl/f8_sync_fifo.sv
// f8_sync_fifo: synchronous FIFO with extra-MSB wrap pointers.
//   clk, rst_n - clock, async active-low reset
//   push, din  - write request and data; ignored when full unless popping
//   pop        - read request; ignored when empty
//   full       - DEPTH entries held
//   empty      - no entries held
//   dout       - head entry (valid when not empty)
module f8_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + (AW+1)'(1);
         if (pop_ok)  rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/f8_uart_tx.sv
// f8_uart_tx: memory-mapped 8N1 UART transmitter with a small write FIFO.
//   clk              - system clock
//   power_on_reset_n - async active-low reset; aborts any frame in flight
//   bus              - f8 I/O bus (DATA write pushes FIFO, STATUS read clears OVF)
//   txd              - registered serial output, idles high
//   irq              - high while FIFO empty and transmitter idle
//
// state | meaning
// IDLE  | line high, waiting for a FIFO entry
// START | start bit (low) for CLK_DIV cycles
// DATA  | shifter[0] on the line for CLK_DIV cycles, 8 bits LSB first
// STOP  | stop bit (high); pops the next byte on its last cycle for gapless frames
module f8_uart_tx
   import f8_uart_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         power_on_reset_n,
   f8_uart_tx_if.slave  bus,
   output logic         txd,
   output logic         irq
);

   localparam int                CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

   uart_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shifter;
   logic             ovf;

   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_head;
   logic             pop;
   logic             data_wr;
   logic             status_rd;
   logic             bit_end;
   logic             busy;

   assign data_wr   = bus.sel && bus.wr && (bus.addr == DATA_ADDR);
   assign status_rd = bus.sel && bus.rd && (bus.addr == STATUS_ADDR);
   assign bit_end   = (cnt == CNT_LAST);
   assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
   assign busy      = (state != IDLE) || !fifo_empty;
   assign irq       = fifo_empty && (state == IDLE);

   f8_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (power_on_reset_n),
      .push  (data_wr),
      .din   (bus.wdata),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_head)
   );

   always_comb begin
      bus.rdata = 8'h00;
      if (bus.addr == STATUS_ADDR) begin
         bus.rdata[FULL_BIT] = fifo_full;
         bus.rdata[BUSY_BIT] = busy;
         bus.rdata[OVF_BIT]  = ovf;
      end
   end

   // Set has priority over the read-clear so a drop on the read cycle is not lost.
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         ovf <= 1'b0;
      end else if (data_wr && fifo_full && !pop) begin
         ovf <= 1'b1;
      end else if (status_rd) begin
         ovf <= 1'b0;
      end
   end

   // txd is assigned the value of the state being entered so it stays registered.
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shifter <= 8'h00;
         txd     <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               txd <= 1'b1;
               if (!fifo_empty) begin
                  shifter <= fifo_head;
                  cnt     <= '0;
                  state   <= START;
                  txd     <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  txd     <= shifter[0];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt     <= '0;
                  shifter <= shifter >> 1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shifter[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (!fifo_empty) begin
                     shifter <= fifo_head;
                     state   <= START;
                     txd     <= 1'b0;
                  end else begin
                     state <= IDLE;
                     txd   <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_f8_uart_tx.sv
// tb_f8_uart_tx: directed self-checking bench for f8_uart_tx with CLK_DIV=4.
module tb_f8_uart_tx;

   localparam int DIV = 4;

   logic clk;
   logic power_on_reset_n;
   logic txd;
   logic irq;

   f8_uart_tx_if bus ();

   f8_uart_tx #(
      .CLK_DIV    (DIV),
      .FIFO_DEPTH (4)
   ) dut (
      .clk              (clk),
      .power_on_reset_n (power_on_reset_n),
      .bus              (bus),
      .txd              (txd),
      .irq              (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic       sel;
      logic       addr;
      logic       wr;
      logic       rd;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_irq;
      logic       exp_txd;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.sel   = 1'b0;
      bus.addr  = 1'b1;
      bus.wr    = 1'b0;
      bus.rd    = 1'b0;
      bus.wdata = 8'h00;
   endtask

   // Write sampled at the next edge; returns 2 time units after that edge.
   task automatic wr_byte(input logic [7:0] b);
      bus.sel   = 1'b1;
      bus.addr  = 1'b0;
      bus.wr    = 1'b1;
      bus.rd    = 1'b0;
      bus.wdata = b;
      tick();
      bus_idle();
      #1;
   endtask

   // Expected line level for sample i (0..39) of a frame carrying b.
   function automatic logic exp_bit(input logic [7:0] b, input int i);
      int seg;
      seg = i / DIV;
      if (seg == 0) return 1'b0;
      if (seg == 9) return 1'b1;
      return b[seg-1];
   endfunction

   // Checks frame samples first..last, one per cycle, ticking after each.
   task automatic expect_line(input logic [7:0] b, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         chk($sformatf("txd_%02h_s%0d", b, i), {7'b0, txd}, {7'b0, exp_bit(b, i)});
         chk($sformatf("irq_%02h_s%0d", b, i), {7'b0, irq}, 8'h00);
         chk($sformatf("busy_%02h_s%0d", b, i), {7'b0, bus.rdata[1]}, 8'h01);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"idle_data",   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
      vecs[1] = '{"idle_status", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
      vecs[2] = '{"nosel_write", 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b1};
      vecs[3] = '{"status_rd",   1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{"data_rd",     1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{"after_reads", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};

      // Reset values
      power_on_reset_n = 1'b0;
      bus_idle();
      bus.addr = 1'b0;
      tick();
      tick();
      chk("rst_txd", {7'b0, txd}, 8'h01);
      chk("rst_irq", {7'b0, irq}, 8'h01);
      chk("rst_data", bus.rdata, 8'h00);
      bus.addr = 1'b1;
      #1;
      chk("rst_status", bus.rdata, 8'h00);
      power_on_reset_n = 1'b1;
      tick();

      // Register access table
      for (int v = 0; v < 6; v++) begin
         bus.sel   = vecs[v].sel;
         bus.addr  = vecs[v].addr;
         bus.wr    = vecs[v].wr;
         bus.rd    = vecs[v].rd;
         bus.wdata = vecs[v].wdata;
         #1;
         chk({vecs[v].name, "_rdata"}, bus.rdata, vecs[v].exp_rdata);
         chk({vecs[v].name, "_irq"}, {7'b0, irq}, {7'b0, vecs[v].exp_irq});
         chk({vecs[v].name, "_txd"}, {7'b0, txd}, {7'b0, vecs[v].exp_txd});
         tick();
      end
      bus_idle();
      #1;

      // Single byte
      wr_byte(8'h55);
      chk("single_irq_fall", {7'b0, irq}, 8'h00);
      tick();
      expect_line(8'h55, 0, 39);
      chk("single_irq_rise", {7'b0, irq}, 8'h01);
      chk("single_txd_idle", {7'b0, txd}, 8'h01);
      tick();

      // Back-to-back
      wr_byte(8'h00);
      wr_byte(8'hFF);
      expect_line(8'h00, 0, 39);
      expect_line(8'hFF, 0, 39);
      chk("b2b_irq", {7'b0, irq}, 8'h01);
      chk("b2b_status", bus.rdata, 8'h00);
      tick();

      // Overflow: 0x01 popped at the second edge, 0x06 dropped
      for (int i = 1; i <= 6; i++) wr_byte(8'(i));
      chk("ovf_status", bus.rdata, 8'h07);
      bus.sel = 1'b1;
      bus.rd  = 1'b1;
      tick();
      bus_idle();
      #1;
      chk("ovf_cleared", bus.rdata, 8'h03);
      expect_line(8'h01, 5, 39);
      for (int i = 2; i <= 5; i++) expect_line(8'(i), 0, 39);
      chk("ovf_irq", {7'b0, irq}, 8'h01);
      chk("ovf_no_06", {7'b0, txd}, 8'h01);
      chk("ovf_status_end", bus.rdata, 8'h00);
      tick();

      // Full FIFO push on the pop edge
      wr_byte(8'h10);
      wr_byte(8'h21);
      wr_byte(8'h32);
      wr_byte(8'h43);
      wr_byte(8'h54);
      chk("full_status", bus.rdata, 8'h03);
      expect_line(8'h10, 3, 38);
      bus.sel   = 1'b1;
      bus.addr  = 1'b0;
      bus.wr    = 1'b1;
      bus.wdata = 8'hA5;
      chk("full_stop_s39", {7'b0, txd}, 8'h01);
      tick();
      bus_idle();
      #1;
      chk("full_pushpop_status", bus.rdata, 8'h03);
      expect_line(8'h21, 0, 39);
      expect_line(8'h32, 0, 39);
      expect_line(8'h43, 0, 39);
      expect_line(8'h54, 0, 39);
      expect_line(8'hA5, 0, 39);
      chk("full_irq", {7'b0, irq}, 8'h01);
      chk("full_status_end", bus.rdata, 8'h00);
      tick();

      // Mid-frame reset during data bit 3, with a second byte queued
      wr_byte(8'h3C);
      wr_byte(8'h99);
      expect_line(8'h3C, 0, 17);
      power_on_reset_n = 1'b0;
      #1;
      chk("mrst_txd", {7'b0, txd}, 8'h01);
      chk("mrst_irq", {7'b0, irq}, 8'h01);
      chk("mrst_status", bus.rdata, 8'h00);
      tick();
      tick();
      power_on_reset_n = 1'b1;
      #1;
      chk("mrst_rel_irq", {7'b0, irq}, 8'h01);
      chk("mrst_rel_status", bus.rdata, 8'h00);
      for (int i = 0; i < 50; i++) begin
         tick();
         chk($sformatf("mrst_quiet_txd_%0d", i), {7'b0, txd}, 8'h01);
         chk($sformatf("mrst_quiet_irq_%0d", i), {7'b0, irq}, 8'h01);
      end
      wr_byte(8'h81);
      tick();
      expect_line(8'h81, 0, 39);
      chk("post_rst_irq", {7'b0, irq}, 8'h01);
      chk("post_rst_status", bus.rdata, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
